// File: rtl/cernbe_arbiter2_pkg.sv
// -----------------------------------------------------------------------------
// cernbe_arb_pkg
// Shared types and defaults for the two-master CERN-BE register-bus arbiter.
//   state_t : arbiter FSM states (IDLE, WAIT)
//   req_t   : one captured master request (pending flag, type, address, data)
// The req_t address field is ADDR_W_DEF bits wide; the arbiter's ADDR_W must
// not exceed it.
// -----------------------------------------------------------------------------
package cernbe_arb_pkg;

  localparam int ADDR_W_DEF  = 13;
  localparam int TIMEOUT_DEF = 255;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  typedef struct packed {
    logic                  pend;
    logic                  wr;
    logic [ADDR_W_DEF-1:0] adr;
    logic [31:0]           dat;
  } req_t;

endpackage

// File: rtl/cernbe_arbiter2_if.sv
// -----------------------------------------------------------------------------
// cernbe_arbiter2_if
// One CERN-BE register bus: single-cycle RdMem/WrMem strobes with address and
// write data from the master side, RdData plus Done/Error pulses back.
//   modport master : drives Addr, WrData, RdMem, WrMem
//   modport slave  : drives RdData, RdDone, WrDone, RdError, WrError
// -----------------------------------------------------------------------------
import cernbe_arb_pkg::*;

interface cernbe_arbiter2_if #(
  parameter int ADDR_W = ADDR_W_DEF
);
  logic [ADDR_W-1:0] Addr;
  logic [31:0]       WrData;
  logic              RdMem;
  logic              WrMem;
  logic [31:0]       RdData;
  logic              RdDone;
  logic              WrDone;
  logic              RdError;
  logic              WrError;

  modport master (
    output Addr, WrData, RdMem, WrMem,
    input  RdData, RdDone, WrDone, RdError, WrError
  );

  modport slave (
    input  Addr, WrData, RdMem, WrMem,
    output RdData, RdDone, WrDone, RdError, WrError
  );
endinterface

// File: rtl/cernbe_arbiter2_req_capture.sv
// -----------------------------------------------------------------------------
// cernbe_req_capture
// Captures one master's single-cycle strobe into a pending request.
//   clk, rst_n      : clock, synchronous active-low reset (clears pend only)
//   rd_i, wr_i      : master strobes; both together count as a write
//   addr_i, dat_i   : address / write data, latched on an accepted strobe
//   busy_i          : this master's transaction is currently in flight
//   grant_i         : arbiter grants this master this cycle; clears pend
//   req_o           : request view = latched request, or the same-cycle
//                     strobe when nothing is latched yet
// -----------------------------------------------------------------------------
import cernbe_arb_pkg::*;

module cernbe_req_capture #(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd_i,
  input  logic              wr_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       dat_i,
  input  logic              busy_i,
  input  logic              grant_i,
  output req_t              req_o
);

  logic                  pend_q, pend_d;
  logic                  wr_q;
  logic [ADDR_W_DEF-1:0] adr_q;
  logic [31:0]           dat_q;
  logic                  acc;

  // A strobe while a request is already pending or in flight is dropped.
  assign acc = (rd_i | wr_i) & ~pend_q & ~busy_i;

  always_comb begin
    pend_d = pend_q;
    if (grant_i)  pend_d = 1'b0;
    else if (acc) pend_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) pend_q <= 1'b0;
    else        pend_q <= pend_d;
  end

  always_ff @(posedge clk) begin
    if (acc) begin
      wr_q  <= wr_i;
      adr_q <= ADDR_W_DEF'(addr_i);
      dat_q <= dat_i;
    end
  end

  // Bypass lets the arbiter grant a strobe in the cycle it arrives.
  always_comb begin
    req_o.pend = pend_q | acc;
    req_o.wr   = pend_q ? wr_q  : wr_i;
    req_o.adr  = pend_q ? adr_q : ADDR_W_DEF'(addr_i);
    req_o.dat  = pend_q ? dat_q : dat_i;
  end

endmodule

// File: rtl/cernbe_arbiter2.sv
// -----------------------------------------------------------------------------
// cernbe_arbiter2
// Two-master round-robin arbiter onto one CERN-BE register bus. Runs one
// transaction at a time, holds address/data until the slave answers, and
// forces an error completion after TIMEOUT WAIT cycles.
//   clk, rst_n : clock, synchronous active-low reset
//   m0, m1     : master-side buses (slave modport: we answer these masters)
//   s          : slave-side bus (master modport: we drive the register map)
// All outputs are registered.
// -----------------------------------------------------------------------------
import cernbe_arb_pkg::*;

module cernbe_arbiter2 #(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  cernbe_arbiter2_if.slave        m0,
  cernbe_arbiter2_if.slave        m1,
  cernbe_arbiter2_if.master       s
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               gnt_q, gnt_d;      // master currently in flight
  logic               wr_q, wr_d;        // type of transaction in flight
  logic               rr_q, rr_d;        // master granted last
  logic [ADDR_W-1:0]  s_addr_q, s_addr_d;
  logic [31:0]        s_wdat_q, s_wdat_d;
  logic               s_rd_q, s_rd_d;
  logic               s_wr_q, s_wr_d;
  logic [1:0]         rd_done_q, rd_done_d;
  logic [1:0]         wr_done_q, wr_done_d;
  logic [1:0]         rd_err_q, rd_err_d;
  logic [1:0]         wr_err_q, wr_err_d;
  logic [1:0][31:0]   rdata_q, rdata_d;

  req_t               req [2];
  logic [1:0]         busy;
  logic [1:0]         grant;
  logic               g;
  req_t               sel;
  logic               resp_ok, resp_err, tmo, err;

  assign busy[0] = (state_q == WAIT) && (gnt_q == 1'b0);
  assign busy[1] = (state_q == WAIT) && (gnt_q == 1'b1);

  cernbe_req_capture #(.ADDR_W(ADDR_W)) u_cap0 (
    .clk     (clk),
    .rst_n   (rst_n),
    .rd_i    (m0.RdMem),
    .wr_i    (m0.WrMem),
    .addr_i  (m0.Addr),
    .dat_i   (m0.WrData),
    .busy_i  (busy[0]),
    .grant_i (grant[0]),
    .req_o   (req[0])
  );

  cernbe_req_capture #(.ADDR_W(ADDR_W)) u_cap1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .rd_i    (m1.RdMem),
    .wr_i    (m1.WrMem),
    .addr_i  (m1.Addr),
    .dat_i   (m1.WrData),
    .busy_i  (busy[1]),
    .grant_i (grant[1]),
    .req_o   (req[1])
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    gnt_d     = gnt_q;
    wr_d      = wr_q;
    rr_d      = rr_q;
    s_addr_d  = s_addr_q;
    s_wdat_d  = s_wdat_q;
    s_rd_d    = 1'b0;
    s_wr_d    = 1'b0;
    rd_done_d = 2'b00;
    wr_done_d = 2'b00;
    rd_err_d  = 2'b00;
    wr_err_d  = 2'b00;
    rdata_d   = rdata_q;
    grant     = 2'b00;
    g         = 1'b0;
    sel       = req[0];
    resp_ok   = 1'b0;
    resp_err  = 1'b0;
    tmo       = 1'b0;
    err       = 1'b0;

    case (state_q)
      IDLE: begin
        if (req[0].pend || req[1].pend) begin
          // On a tie the master not granted last wins.
          g        = (req[0].pend && req[1].pend) ? ~rr_q : req[1].pend;
          sel      = g ? req[1] : req[0];
          grant[g] = 1'b1;
          gnt_d    = g;
          rr_d     = g;
          wr_d     = sel.wr;
          s_addr_d = ADDR_W'(sel.adr);
          s_wdat_d = sel.dat;
          s_wr_d   = sel.wr;
          s_rd_d   = ~sel.wr;
          cnt_d    = '0;
          state_d  = WAIT;
        end
      end
      WAIT: begin
        // Only responses matching the in-flight type count.
        resp_ok  = wr_q ? s.WrDone  : s.RdDone;
        resp_err = wr_q ? s.WrError : s.RdError;
        // cnt_q reaches TIMEOUT-1 in the TIMEOUT-th WAIT cycle.
        tmo      = (cnt_q == CNT_W'(TIMEOUT - 1));
        if (resp_ok || resp_err || tmo) begin
          err     = resp_err | ~resp_ok;
          state_d = IDLE;
          if (wr_q) begin
            wr_done_d[gnt_q] = 1'b1;
            wr_err_d[gnt_q]  = err;
          end else begin
            rd_done_d[gnt_q] = 1'b1;
            rd_err_d[gnt_q]  = err;
            rdata_d[gnt_q]   = err ? 32'h0 : s.RdData;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      gnt_q     <= 1'b0;
      wr_q      <= 1'b0;
      rr_q      <= 1'b1;
      s_addr_q  <= '0;
      s_wdat_q  <= '0;
      s_rd_q    <= 1'b0;
      s_wr_q    <= 1'b0;
      rd_done_q <= 2'b00;
      wr_done_q <= 2'b00;
      rd_err_q  <= 2'b00;
      wr_err_q  <= 2'b00;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      gnt_q     <= gnt_d;
      wr_q      <= wr_d;
      rr_q      <= rr_d;
      s_addr_q  <= s_addr_d;
      s_wdat_q  <= s_wdat_d;
      s_rd_q    <= s_rd_d;
      s_wr_q    <= s_wr_d;
      rd_done_q <= rd_done_d;
      wr_done_q <= wr_done_d;
      rd_err_q  <= rd_err_d;
      wr_err_q  <= wr_err_d;
      rdata_q   <= rdata_d;
    end
  end

  assign s.Addr     = s_addr_q;
  assign s.WrData   = s_wdat_q;
  assign s.RdMem    = s_rd_q;
  assign s.WrMem    = s_wr_q;

  assign m0.RdData  = rdata_q[0];
  assign m0.RdDone  = rd_done_q[0];
  assign m0.WrDone  = wr_done_q[0];
  assign m0.RdError = rd_err_q[0];
  assign m0.WrError = wr_err_q[0];

  assign m1.RdData  = rdata_q[1];
  assign m1.RdDone  = rd_done_q[1];
  assign m1.WrDone  = wr_done_q[1];
  assign m1.RdError = rd_err_q[1];
  assign m1.WrError = wr_err_q[1];

endmodule

// File: tb/tb_cernbe_arbiter2.sv
// -----------------------------------------------------------------------------
// tb_cernbe_arbiter2
// Directed bench for cernbe_arbiter2 (ADDR_W=13, TIMEOUT=4). Inputs change
// 1 time unit after the rising edge; outputs are sampled at the same point.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_cernbe_arbiter2;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;

  cernbe_arbiter2_if #(.ADDR_W(13)) m0_if ();
  cernbe_arbiter2_if #(.ADDR_W(13)) m1_if ();
  cernbe_arbiter2_if #(.ADDR_W(13)) s_if ();

  cernbe_arbiter2 #(.ADDR_W(13), .TIMEOUT(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .m0    (m0_if),
    .m1    (m1_if),
    .s     (s_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] fl0();
    return {m0_if.RdDone, m0_if.WrDone, m0_if.RdError, m0_if.WrError};
  endfunction

  function automatic logic [3:0] fl1();
    return {m1_if.RdDone, m1_if.WrDone, m1_if.RdError, m1_if.WrError};
  endfunction

  // Enter in the slave-strobe cycle of a write; answer WrDone one cycle
  // later and return in the cycle the master Done is visible.
  task automatic serve_wr(input string tag, input logic [12:0] a, input logic [31:0] d);
    chk({tag, "_swr"}, s_if.WrMem, 1);
    chk({tag, "_sadr"}, s_if.Addr, a);
    chk({tag, "_sdat"}, s_if.WrData, d);
    tick();
    chk({tag, "_swr_pulse"}, s_if.WrMem, 0);
    chk({tag, "_sdat_hold"}, s_if.WrData, d);
    s_if.WrDone = 1'b1;
    tick();
    s_if.WrDone = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    m0_if.Addr = '0; m0_if.WrData = '0; m0_if.RdMem = 1'b0; m0_if.WrMem = 1'b0;
    m1_if.Addr = '0; m1_if.WrData = '0; m1_if.RdMem = 1'b0; m1_if.WrMem = 1'b0;
    s_if.RdData = '0; s_if.RdDone = 1'b0; s_if.WrDone = 1'b0;
    s_if.RdError = 1'b0; s_if.WrError = 1'b0;

    // ---- reset state
    tick();
    tick();
    chk("rst_s_rd", s_if.RdMem, 0);
    chk("rst_s_wr", s_if.WrMem, 0);
    chk("rst_s_adr", s_if.Addr, 0);
    chk("rst_s_dat", s_if.WrData, 0);
    chk("rst_m0_fl", fl0(), 0);
    chk("rst_m1_fl", fl1(), 0);
    chk("rst_m0_rdat", m0_if.RdData, 0);
    rst_n = 1'b1;
    tick();

    // ---- m0 read 0x005, slave answers two cycles after s_RdMem
    m0_if.Addr = 13'h005; m0_if.RdMem = 1'b1;
    tick();
    m0_if.RdMem = 1'b0;
    chk("t1_s_rd", s_if.RdMem, 1);
    chk("t1_s_adr", s_if.Addr, 13'h005);
    tick();
    chk("t1_s_rd_pulse", s_if.RdMem, 0);
    chk("t1_adr_hold", s_if.Addr, 13'h005);
    tick();
    chk("t1_no_early", m0_if.RdDone, 0);
    s_if.RdData = 32'hDEADBEEF; s_if.RdDone = 1'b1;
    tick();
    s_if.RdDone = 1'b0; s_if.RdData = 32'h0;
    chk("t1_m0_fl", fl0(), 4'b1000);
    chk("t1_m0_rdat", m0_if.RdData, 32'hDEADBEEF);
    chk("t1_m1_fl", fl1(), 0);
    tick();
    chk("t1_m0_done_pulse", m0_if.RdDone, 0);
    chk("t1_m0_rdat_hold", m0_if.RdData, 32'hDEADBEEF);

    // ---- m1 normal read, slave answers in first WAIT cycle
    m1_if.Addr = 13'h007; m1_if.RdMem = 1'b1;
    tick();
    m1_if.RdMem = 1'b0;
    chk("t1b_s_rd", s_if.RdMem, 1);
    chk("t1b_s_adr", s_if.Addr, 13'h007);
    s_if.RdData = 32'h12345678; s_if.RdDone = 1'b1;
    tick();
    s_if.RdDone = 1'b0; s_if.RdData = 32'h0;
    chk("t1b_m1_fl", fl1(), 4'b1000);
    chk("t1b_m1_rdat", m1_if.RdData, 32'h12345678);
    chk("t1b_m0_fl", fl0(), 0);

    // ---- simultaneous writes, then continuous alternating load
    m0_if.Addr = 13'h010; m0_if.WrData = 32'h11111111; m0_if.WrMem = 1'b1;
    m1_if.Addr = 13'h020; m1_if.WrData = 32'h22222222; m1_if.WrMem = 1'b1;
    tick();
    m0_if.WrMem = 1'b0; m1_if.WrMem = 1'b0;
    serve_wr("t2a", 13'h010, 32'h11111111);
    chk("t2a_m0_fl", fl0(), 4'b0100);
    chk("t2a_m1_fl", fl1(), 0);
    m0_if.Addr = 13'h030; m0_if.WrData = 32'h33333333; m0_if.WrMem = 1'b1;
    tick();
    m0_if.WrMem = 1'b0;
    serve_wr("t2b", 13'h020, 32'h22222222);
    chk("t2b_m1_fl", fl1(), 4'b0100);
    chk("t2b_m0_fl", fl0(), 0);
    m1_if.Addr = 13'h040; m1_if.WrData = 32'h44444444; m1_if.WrMem = 1'b1;
    tick();
    m1_if.WrMem = 1'b0;
    serve_wr("t2c", 13'h030, 32'h33333333);
    chk("t2c_m0_fl", fl0(), 4'b0100);
    tick();
    serve_wr("t2d", 13'h040, 32'h44444444);
    chk("t2d_m1_fl", fl1(), 4'b0100);

    // ---- m1 read, slave silent: timeout after 4 WAIT cycles
    tick();
    m1_if.Addr = 13'h009; m1_if.RdMem = 1'b1;
    tick();
    m1_if.RdMem = 1'b0;
    chk("t3_s_rd", s_if.RdMem, 1);
    for (int c = 2; c < 6; c++) begin
      chk($sformatf("t3_no_done_c%0d", c), m1_if.RdDone, 0);
      tick();
    end
    chk("t3_m1_fl", fl1(), 4'b1010);
    chk("t3_m1_rdat", m1_if.RdData, 0);
    tick();
    tick();
    s_if.RdData = 32'hBAD0BAD0; s_if.RdDone = 1'b1;
    tick();
    s_if.RdDone = 1'b0; s_if.RdData = 32'h0;
    chk("t3_late_m1_fl", fl1(), 0);
    chk("t3_late_m0_fl", fl0(), 0);
    chk("t3_late_rdat", m1_if.RdData, 0);
    chk("t3_late_s_rd", s_if.RdMem, 0);

    // ---- slave write error on m0, pending m1 read then proceeds
    m0_if.Addr = 13'h050; m0_if.WrData = 32'h55555555; m0_if.WrMem = 1'b1;
    m1_if.Addr = 13'h060; m1_if.RdMem = 1'b1;
    tick();
    m0_if.WrMem = 1'b0; m1_if.RdMem = 1'b0;
    chk("t4_s_wr", s_if.WrMem, 1);
    chk("t4_s_adr", s_if.Addr, 13'h050);
    s_if.RdDone = 1'b1;
    tick();
    s_if.RdDone = 1'b0;
    chk("t4_wrong_type_ign", fl0(), 0);
    s_if.WrError = 1'b1;
    tick();
    s_if.WrError = 1'b0;
    chk("t4_m0_fl", fl0(), 4'b0101);
    chk("t4_m1_fl", fl1(), 0);
    tick();
    chk("t4_s_rd", s_if.RdMem, 1);
    chk("t4_s_adr2", s_if.Addr, 13'h060);
    s_if.RdData = 32'hCAFEF00D; s_if.RdDone = 1'b1;
    tick();
    s_if.RdDone = 1'b0; s_if.RdData = 32'h0;
    chk("t4_m1_fl2", fl1(), 4'b1000);
    chk("t4_m1_rdat", m1_if.RdData, 32'hCAFEF00D);

    // ---- reset during WAIT with m1 pending
    m0_if.Addr = 13'h070; m0_if.RdMem = 1'b1;
    m1_if.Addr = 13'h071; m1_if.RdMem = 1'b1;
    tick();
    m0_if.RdMem = 1'b0; m1_if.RdMem = 1'b0;
    chk("t5_s_adr", s_if.Addr, 13'h070);
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("t5_s_adr0", s_if.Addr, 0);
    chk("t5_s_rd0", s_if.RdMem, 0);
    chk("t5_m0_rdat0", m0_if.RdData, 0);
    chk("t5_m1_rdat0", m1_if.RdData, 0);
    s_if.RdData = 32'h77777777; s_if.RdDone = 1'b1;
    tick();
    s_if.RdDone = 1'b0; s_if.RdData = 32'h0;
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("t5_quiet_fl_c%0d", c), {fl0(), fl1()}, 0);
      chk($sformatf("t5_quiet_srd_c%0d", c), s_if.RdMem, 0);
      tick();
    end
    m0_if.Addr = 13'h080; m0_if.WrData = 32'h88888888; m0_if.WrMem = 1'b1;
    m1_if.Addr = 13'h081; m1_if.WrData = 32'h99999999; m1_if.WrMem = 1'b1;
    tick();
    m0_if.WrMem = 1'b0; m1_if.WrMem = 1'b0;
    serve_wr("t5a", 13'h080, 32'h88888888);
    chk("t5a_m0_fl", fl0(), 4'b0100);
    tick();
    serve_wr("t5b", 13'h081, 32'h99999999);
    chk("t5b_m1_fl", fl1(), 4'b0100);

    // ---- m0 RdMem+WrMem together, plus a dropped strobe while busy
    m0_if.Addr = 13'h090; m0_if.WrData = 32'hAAAA5555;
    m0_if.RdMem = 1'b1; m0_if.WrMem = 1'b1;
    tick();
    m0_if.WrMem = 1'b0;
    chk("t6_s_wr", s_if.WrMem, 1);
    chk("t6_s_rd", s_if.RdMem, 0);
    chk("t6_s_dat", s_if.WrData, 32'hAAAA5555);
    tick();
    m0_if.RdMem = 1'b0;
    s_if.WrDone = 1'b1;
    tick();
    s_if.WrDone = 1'b0;
    chk("t6_m0_fl", fl0(), 4'b0100);
    tick();
    chk("t6_drop_c1", {s_if.RdMem, s_if.WrMem}, 0);
    tick();
    chk("t6_drop_c2", {s_if.RdMem, s_if.WrMem}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
